// File: rtl/behav_updown_counter_pkg.sv
// Shared widths, operation encoding and the wrap-aware step function
// for the behavioural up/down counter.
package behav_counter_pkg;

  localparam int CNT_W   = 8;
  localparam int PRE_W   = 16;
  localparam int PULSE_W = 8;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_LOAD = 2'b01,
    OP_TICK = 2'b10
  } cnt_op_e;

  // Bit CNT_W of the result is the carry (up) or borrow (down) out of the 9-bit step.
  function automatic logic [CNT_W:0] next_count(
    input logic [CNT_W-1:0] qd,
    input logic [CNT_W-1:0] step,
    input logic             up
  );
    logic [CNT_W:0] ext_s;
    if (up) begin
      ext_s = {1'b0, qd} + {1'b0, step};
    end else begin
      ext_s = {1'b0, qd} - {1'b0, step};
    end
    return ext_s;
  endfunction

endpackage

// File: rtl/behav_updown_counter_if.sv
// Load/count control and status bundle of the up/down counter.
interface behav_updown_counter_if;
  import behav_counter_pkg::*;

  logic [CNT_W-1:0] d;
  logic             load;
  logic [CNT_W-1:0] load_b;
  logic             up_down;
  logic [CNT_W-1:0] qd;
  logic             qd_b;
  logic             qd_c;

  modport master (
    output d, load, load_b, up_down,
    input  qd, qd_b, qd_c
  );

  modport slave (
    input  d, load, load_b, up_down,
    output qd, qd_b, qd_c
  );

endinterface

// File: rtl/behav_updown_counter_pulse_stretch.sv
// Retriggerable pulse stretcher: a trigger starts (or restarts) a LEN-clock
// registered pulse that begins on the same edge that samples the trigger.
module pulse_stretch #(
  parameter int unsigned LEN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger,
  output logic pulse
);
  import behav_counter_pkg::*;

  localparam logic [PULSE_W-1:0] LEN_M1    = PULSE_W'(LEN - 32'd1);
  localparam logic [PULSE_W-1:0] PULSE_ONE = PULSE_W'(32'd1);
  localparam logic [PULSE_W-1:0] PULSE_ZERO = PULSE_W'(32'd0);

  logic [PULSE_W-1:0] remain_r;
  logic               pulse_r;

  // Remaining-clocks counter and registered pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain_r <= PULSE_ZERO;
      pulse_r  <= 1'b0;
    end else if (trigger) begin
      remain_r <= LEN_M1;
      pulse_r  <= 1'b1;
    end else if (remain_r != PULSE_ZERO) begin
      remain_r <= remain_r - PULSE_ONE;
      pulse_r  <= 1'b1;
    end else begin
      remain_r <= PULSE_ZERO;
      pulse_r  <= 1'b0;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/behav_updown_counter.sv
// 8-bit up/down counter with masked parallel load, prescaled step, terminal-count
// flag and a stretched carry/borrow pulse.
module behav_updown_counter #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned KEEP_WIDTH = 1,
  parameter int unsigned HDR_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  behav_updown_counter_if.slave bus
);
  import behav_counter_pkg::*;

  localparam logic [CNT_W-1:0] STEP     = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] UP_LIMIT = CNT_W'(32'd255 - DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(KEEP_WIDTH - 32'd1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(32'd1);
  localparam logic [PRE_W-1:0] PRE_ZERO = PRE_W'(32'd0);

  logic [1:0]       rst_sync_r;
  logic             rst_int_n_s;
  logic [CNT_W-1:0] qd_r;
  logic [PRE_W-1:0] pre_r;
  logic             tick_s;
  logic [CNT_W:0]   next_s;
  cnt_op_e          op_s;
  logic [CNT_W-1:0] qd_next_s;
  logic [PRE_W-1:0] pre_next_s;
  logic             wrap_s;
  logic             qd_b_s;
  logic             qd_c_s;

  // Reset synchroniser: assertion is immediate, release waits two clocks.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_int_n_s = rst_sync_r[1];

  assign tick_s = (pre_r == PRE_LAST);
  assign next_s = next_count(qd_r, STEP, bus.up_down);

  // Operation select: load wins over a count tick.
  always_comb begin
    op_s = OP_HOLD;
    if (bus.load) begin
      op_s = OP_LOAD;
    end else if (tick_s) begin
      op_s = OP_TICK;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next counter/prescaler values; wrap is only reported for a real count tick.
  always_comb begin
    qd_next_s  = qd_r;
    pre_next_s = pre_r;
    wrap_s     = 1'b0;
    case (op_s)
      OP_LOAD: begin
        qd_next_s  = (bus.d & bus.load_b) | (qd_r & ~bus.load_b);
        pre_next_s = PRE_ZERO;
      end
      OP_TICK: begin
        qd_next_s  = next_s[CNT_W-1:0];
        pre_next_s = PRE_ZERO;
        wrap_s     = next_s[CNT_W];
      end
      OP_HOLD: begin
        pre_next_s = pre_r + PRE_ONE;
      end
      default: begin
        qd_next_s  = qd_r;
        pre_next_s = pre_r;
      end
    endcase
  end

  // Counter value and prescaler state.
  always_ff @(posedge clk or negedge rst_int_n_s) begin
    if (!rst_int_n_s) begin
      qd_r  <= CNT_ZERO;
      pre_r <= PRE_ZERO;
    end else begin
      qd_r  <= qd_next_s;
      pre_r <= pre_next_s;
    end
  end

  // Terminal count follows direction changes without waiting for a tick.
  always_comb begin
    qd_b_s = 1'b0;
    if (bus.up_down) begin
      qd_b_s = (qd_r > UP_LIMIT);
    end else begin
      qd_b_s = (qd_r < STEP);
    end
  end

  pulse_stretch #(
    .LEN (HDR_WIDTH)
  ) u_pulse (
    .clk     (clk),
    .rst_n   (rst_int_n_s),
    .trigger (wrap_s),
    .pulse   (qd_c_s)
  );

  assign bus.qd   = qd_r;
  assign bus.qd_b = qd_b_s;
  assign bus.qd_c = qd_c_s;

endmodule

// File: tb/tb_behav_updown_counter.sv
// Directed scoreboard bench for behav_updown_counter across three parameter sets.
module tb_behav_updown_counter;
  import behav_counter_pkg::*;

  logic clk = 1'b0;
  logic clear;

  always #5 clk = ~clk;

  behav_updown_counter_if bus0 ();
  behav_updown_counter_if bus1 ();
  behav_updown_counter_if bus2 ();

  behav_updown_counter #(.DATA_WIDTH(1), .KEEP_WIDTH(1), .HDR_WIDTH(1)) u0 (
    .clk(clk), .clear(clear), .bus(bus0));
  behav_updown_counter #(.DATA_WIDTH(3), .KEEP_WIDTH(1), .HDR_WIDTH(4)) u1 (
    .clk(clk), .clear(clear), .bus(bus1));
  behav_updown_counter #(.DATA_WIDTH(1), .KEEP_WIDTH(4), .HDR_WIDTH(1)) u2 (
    .clk(clk), .clear(clear), .bus(bus2));

  typedef struct packed {
    logic [7:0] qd;
    logic       qd_b;
    logic       qd_c;
  } obs_t;

  typedef struct {
    int    unit;
    string tag;
    obs_t  exp;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  function automatic obs_t get_obs(int unit);
    obs_t o;
    case (unit)
      0:       o = {bus0.qd, bus0.qd_b, bus0.qd_c};
      1:       o = {bus1.qd, bus1.qd_b, bus1.qd_c};
      2:       o = {bus2.qd, bus2.qd_b, bus2.qd_c};
      default: o = 10'bx;
    endcase
    return o;
  endfunction

  task automatic drive(logic [7:0] d, logic load, logic [7:0] load_b, logic up);
    bus0.d = d; bus0.load = load; bus0.load_b = load_b; bus0.up_down = up;
    bus1.d = d; bus1.load = load; bus1.load_b = load_b; bus1.up_down = up;
    bus2.d = d; bus2.load = load; bus2.load_b = load_b; bus2.up_down = up;
  endtask

  task automatic expect_out(int unit, string tag, logic [7:0] qd, logic b, logic c);
    sb_t e;
    e.unit = unit;
    e.tag  = tag;
    e.exp  = {qd, b, c};
    sb_q.push_back(e);
  endtask

  task automatic check_out();
    sb_t  e;
    obs_t o;
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed nothing queued, required one entry");
    end else begin
      e = sb_q.pop_front();
      o = get_obs(e.unit);
      assert (o === e.exp) else begin
        bad++;
        $error("FAIL %s: observed qd=%h qd_b=%b qd_c=%b, required qd=%h qd_b=%b qd_c=%b",
               e.tag, o.qd, o.qd_b, o.qd_c, e.exp.qd, e.exp.qd_b, e.exp.qd_c);
      end
    end
  endtask

  // One clock, then compare the DUT against the queued expectation.
  task automatic step(int unit, string tag, logic [7:0] qd, logic b, logic c);
    expect_out(unit, tag, qd, b, c);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Compare without a clock edge (combinational / asynchronous behaviour).
  task automatic now_chk(int unit, string tag, logic [7:0] qd, logic b, logic c);
    #1;
    expect_out(unit, tag, qd, b, c);
    check_out();
  endtask

  task automatic hold_clear(logic up);
    clear = 1'b0;
    drive(8'h00, 1'b0, 8'hFF, up);
    #2;
  endtask

  task automatic release_clear();
    @(posedge clk);
    #1;
    clear = 1'b1;
  endtask

  initial begin
    // Test 1: reset state and plain up-count, step 1
    hold_clear(1'b1);
    now_chk(0, "t1_reset", 8'h00, 1'b0, 1'b0);
    release_clear();
    step(0, "t1_sync0", 8'h00, 1'b0, 1'b0);
    step(0, "t1_sync1", 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(0, "t1_count", 8'(i), 1'b0, 1'b0);
    end

    // Test 2: wrap FF -> 00 with a one-clock carry
    drive(8'hFE, 1'b1, 8'hFF, 1'b1);
    step(0, "t2_load_fe", 8'hFE, 1'b0, 1'b0);
    drive(8'hFE, 1'b0, 8'hFF, 1'b1);
    step(0, "t2_ff_term", 8'hFF, 1'b1, 1'b0);
    step(0, "t2_wrap", 8'h00, 1'b0, 1'b1);
    step(0, "t2_carry_end", 8'h01, 1'b0, 1'b0);

    // Test 3: masked load, no tick on a load cycle
    drive(8'h05, 1'b1, 8'hFF, 1'b1);
    step(0, "t3_load_05", 8'h05, 1'b0, 1'b0);
    drive(8'hA0, 1'b1, 8'hF0, 1'b1);
    step(0, "t3_masked", 8'hA5, 1'b0, 1'b0);
    drive(8'hA0, 1'b0, 8'hF0, 1'b1);
    step(0, "t3_resume", 8'hA6, 1'b0, 1'b0);

    // Test 4: step 3 down-count, 4-clock borrow pulse, terminal-count boundaries
    hold_clear(1'b0);
    now_chk(1, "t4_reset_down", 8'h00, 1'b1, 1'b0);
    release_clear();
    step(1, "t4_sync0", 8'h00, 1'b1, 1'b0);
    step(1, "t4_sync1", 8'h00, 1'b1, 1'b0);
    step(1, "t4_wrap_fd", 8'hFD, 1'b0, 1'b1);
    step(1, "t4_fa", 8'hFA, 1'b0, 1'b1);
    step(1, "t4_f7", 8'hF7, 1'b0, 1'b1);
    step(1, "t4_f4", 8'hF4, 1'b0, 1'b1);
    step(1, "t4_f1_end", 8'hF1, 1'b0, 1'b0);
    drive(8'h01, 1'b1, 8'hFF, 1'b0);
    step(1, "t4_tc_01", 8'h01, 1'b1, 1'b0);
    drive(8'h02, 1'b1, 8'hFF, 1'b0);
    step(1, "t4_tc_02", 8'h02, 1'b1, 1'b0);
    drive(8'h03, 1'b1, 8'hFF, 1'b0);
    step(1, "t4_tc_03", 8'h03, 1'b0, 1'b0);
    drive(8'hFD, 1'b1, 8'hFF, 1'b1);
    step(1, "t4_up_fd", 8'hFD, 1'b1, 1'b0);
    drive(8'hFD, 1'b1, 8'hFF, 1'b0);
    now_chk(1, "t4_dir_flip", 8'hFD, 1'b0, 1'b0);
    drive(8'hFC, 1'b1, 8'hFF, 1'b1);
    step(1, "t4_up_fc", 8'hFC, 1'b0, 1'b0);
    // Borrow, load inside the pulse, then a retrigger restarts the full length
    drive(8'h02, 1'b1, 8'hFF, 1'b0);
    step(1, "t4_load_02", 8'h02, 1'b1, 1'b0);
    drive(8'h02, 1'b0, 8'hFF, 1'b0);
    step(1, "t4_wrap_ff", 8'hFF, 1'b0, 1'b1);
    step(1, "t4_fc", 8'hFC, 1'b0, 1'b1);
    drive(8'h01, 1'b1, 8'hFF, 1'b0);
    step(1, "t4_load_in_pulse", 8'h01, 1'b1, 1'b1);
    drive(8'h01, 1'b0, 8'hFF, 1'b0);
    step(1, "t4_retrig_fe", 8'hFE, 1'b0, 1'b1);
    step(1, "t4_retrig_fb", 8'hFB, 1'b0, 1'b1);
    step(1, "t4_retrig_f8", 8'hF8, 1'b0, 1'b1);
    step(1, "t4_retrig_f5", 8'hF5, 1'b0, 1'b1);
    step(1, "t4_retrig_end", 8'hF2, 1'b0, 1'b0);

    // Test 5: prescaler of 4, load restarts the period
    hold_clear(1'b1);
    now_chk(2, "t5_reset", 8'h00, 1'b0, 1'b0);
    release_clear();
    step(2, "t5_sync0", 8'h00, 1'b0, 1'b0);
    step(2, "t5_sync1", 8'h00, 1'b0, 1'b0);
    for (int r = 1; r <= 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        step(2, "t5_hold", 8'(r - 1), 1'b0, 1'b0);
      end
      step(2, "t5_tick", 8'(r), 1'b0, 1'b0);
    end
    step(2, "t5_pre1", 8'h02, 1'b0, 1'b0);
    step(2, "t5_pre2", 8'h02, 1'b0, 1'b0);
    drive(8'h10, 1'b1, 8'hFF, 1'b1);
    step(2, "t5_load_mid", 8'h10, 1'b0, 1'b0);
    drive(8'h10, 1'b0, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(2, "t5_restart_hold", 8'h10, 1'b0, 1'b0);
    end
    step(2, "t5_restart_tick", 8'h11, 1'b0, 1'b0);

    // Test 6: clear in the middle of an active borrow pulse
    hold_clear(1'b0);
    release_clear();
    step(1, "t6_sync0", 8'h00, 1'b1, 1'b0);
    step(1, "t6_sync1", 8'h00, 1'b1, 1'b0);
    step(1, "t6_wrap", 8'hFD, 1'b0, 1'b1);
    step(1, "t6_pulse", 8'hFA, 1'b0, 1'b1);
    #2;
    clear = 1'b0;
    now_chk(1, "t6_async_clear", 8'h00, 1'b1, 1'b0);
    now_chk(0, "t6_async_clear_u0", 8'h00, 1'b1, 1'b0);
    step(1, "t6_clear_held", 8'h00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
